// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: frame state encodings and baud divisor helper.
// Intended for reuse by the transmitter and the planned receiver.
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per bit, truncated toward zero.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame_baud_div.sv
// Bit-period counter: counts 0..DIV-1 while run is high, tick at DIV-1.
// Ports: clk, rst_n (sync, active low), clr, run in; tick out.
module uart_baud_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with ready/start handshake.
// Ports: clk, rst_n, txEn, txStart, in_data in; txReady, tx, txBusy, txDone out.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 txEn,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 txReady,
    output logic                 tx,
    output logic                 txBusy,
    output logic                 txDone
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_frame: CLK_FREQ/BAUD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_state_t          r_state, w_state_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx, w_shifted;
    logic [3:0]           r_bitcnt, w_bitcnt_nx;
    logic                 r_par, w_par_nx;
    logic                 r_tx, w_tx_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_ready, w_ready_nx;
    logic                 r_done, w_done_nx;
    logic                 w_tick, w_accept, w_srst_n;

    // Disable behaves exactly like reset.
    assign w_srst_n = rst_n & txEn;
    assign w_accept = (r_state == IDLE) & txStart;

    uart_baud_div #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (w_srst_n),
        .clr   (w_accept),
        .run   (r_state != IDLE),
        .tick  (w_tick)
    );

    // The bit on the line is always the leading end of the shifter.
    function automatic logic first_bit(input logic [DATA_BITS-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_BITS-1] : v[0];
    endfunction

    assign w_shifted = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

    always_ff @(posedge clk) begin
        if (!w_srst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_shift  <= w_shift_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_par    <= w_par_nx;
            r_tx     <= w_tx_nx;
            r_busy   <= w_busy_nx;
            r_ready  <= w_ready_nx;
            r_done   <= w_done_nx;
        end
    end

    // Outputs are registered: each transition loads the value the line
    // must carry during the state being entered.
    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_bitcnt_nx = r_bitcnt;
        w_par_nx    = r_par;
        w_tx_nx     = r_tx;
        w_busy_nx   = r_busy;
        w_ready_nx  = r_ready;
        w_done_nx   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (txStart) begin
                    w_state_nx  = START;
                    w_shift_nx  = in_data;
                    w_par_nx    = (^in_data) ^ ODD;
                    w_bitcnt_nx = '0;
                    w_tx_nx     = 1'b0;
                    w_busy_nx   = 1'b1;
                    w_ready_nx  = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nx = DATA;
                    w_tx_nx    = first_bit(r_shift);
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nx = '0;
                        if (PARITY_EN != 0) begin
                            w_state_nx = PARITY;
                            w_tx_nx    = r_par;
                        end else begin
                            w_state_nx = STOP;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_bitcnt_nx = r_bitcnt + 4'd1;
                        w_shift_nx  = w_shifted;
                        w_tx_nx     = first_bit(w_shifted);
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_nx  = STOP;
                    w_bitcnt_nx = '0;
                    w_tx_nx     = 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bitcnt == LAST_STOP) begin
                        w_state_nx  = IDLE;
                        w_bitcnt_nx = '0;
                        w_busy_nx   = 1'b0;
                        w_ready_nx  = 1'b1;
                        w_done_nx   = 1'b1;
                    end else begin
                        w_bitcnt_nx = r_bitcnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign tx      = r_tx;
    assign txBusy  = r_busy;
    assign txReady = r_ready;
    assign txDone  = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: four configurations at DIV=4.
// Ports driven: clk, rst_n, txEn, txStart, in_data; all outputs checked.
module tb_uart_tx_frame;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            txEn = 1'b1;
    logic [3:0]      start_r = '0;
    logic [3:0][8:0] din = '0;
    logic [3:0]      tx_w, busy_w, ready_w, done_w;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt[4] = '{0, 0, 0, 0};

    typedef struct {
        int          dut;
        logic [15:0] bits;
        int          nbits;
    } exp_t;

    typedef struct {
        int          dut;
        logic [8:0]  data;
        logic [15:0] bits;
        int          nbits;
        int          pulse_at;
    } vec_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // 8N1
    uart_tx_frame #(
        .CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .txEn(txEn), .txStart(start_r[0]),
        .in_data(din[0][7:0]), .txReady(ready_w[0]), .tx(tx_w[0]),
        .txBusy(busy_w[0]), .txDone(done_w[0])
    );

    // 8E1
    uart_tx_frame #(
        .CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .txEn(txEn), .txStart(start_r[1]),
        .in_data(din[1][7:0]), .txReady(ready_w[1]), .tx(tx_w[1]),
        .txBusy(busy_w[1]), .txDone(done_w[1])
    );

    // 8O2
    uart_tx_frame #(
        .CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(2), .MSB_FIRST(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .txEn(txEn), .txStart(start_r[2]),
        .in_data(din[2][7:0]), .txReady(ready_w[2]), .tx(tx_w[2]),
        .txBusy(busy_w[2]), .txDone(done_w[2])
    );

    // 7N1, MSB first
    uart_tx_frame #(
        .CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .txEn(txEn), .txStart(start_r[3]),
        .in_data(din[3][6:0]), .txReady(ready_w[3]), .tx(tx_w[3]),
        .txBusy(busy_w[3]), .txDone(done_w[3])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i]) done_cnt[i]++;
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the first frame cycle.
    task automatic begin_frame(input int d, input logic [8:0] data,
                               input logic [15:0] bits, input int n,
                               input bit hold);
        exp_t e;
        chk("idle_ready", 16'(ready_w[d]), 16'd1);
        chk("idle_tx", 16'(tx_w[d]), 16'd1);
        start_r[d] = 1'b1;
        din[d] = data;
        e.dut = d;
        e.bits = bits;
        e.nbits = n;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start_r[d] = 1'b0;
    endtask

    // Walks the whole frame, returns at the completion cycle.
    task automatic check_frame(input int pulse_at);
        exp_t e;
        int d;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty @%0t", $time);
            return;
        end
        e = sb.pop_front();
        d = e.dut;
        for (int k = 0; k < e.nbits * 4; k++) begin
            if (pulse_at >= 0 && k == pulse_at) begin
                start_r[d] = 1'b1;
                din[d] = 9'h1FF;
            end
            if (pulse_at >= 0 && k == pulse_at + 1) start_r[d] = 1'b0;
            chk($sformatf("tx_d%0d_k%0d", d, k), 16'(tx_w[d]),
                16'(e.bits[15 - k / 4]));
            chk("busy_frame", 16'(busy_w[d]), 16'd1);
            chk("ready_frame", 16'(ready_w[d]), 16'd0);
            chk("done_frame", 16'(done_w[d]), 16'd0);
            @(negedge clk);
        end
        chk("done_end", 16'(done_w[d]), 16'd1);
        chk("busy_end", 16'(busy_w[d]), 16'd0);
        chk("ready_end", 16'(ready_w[d]), 16'd1);
        chk("tx_end", 16'(tx_w[d]), 16'd1);
    endtask

    task automatic abort_test(input bit use_en);
        exp_t e;
        int c0, lows;
        c0 = done_cnt[0];
        lows = 0;
        begin_frame(0, 9'h0A5, 16'b0101001011_000000, 10, 1'b0);
        e = sb.pop_front();
        for (int k = 0; k < 16; k++) begin
            chk("abort_pre_tx", 16'(tx_w[0]), 16'(e.bits[15 - k / 4]));
            @(negedge clk);
        end
        if (use_en) txEn = 1'b0;
        else rst_n = 1'b0;
        @(negedge clk);
        txEn = 1'b1;
        rst_n = 1'b1;
        chk("abort_tx", 16'(tx_w[0]), 16'd1);
        chk("abort_busy", 16'(busy_w[0]), 16'd0);
        chk("abort_ready", 16'(ready_w[0]), 16'd1);
        for (int k = 0; k < 45; k++) begin
            if (tx_w[0] !== 1'b1) lows++;
            @(negedge clk);
        end
        chk("abort_line_idle", 16'(lows), 16'd0);
        chk("abort_no_done", 16'(done_cnt[0] - c0), 16'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int c0;
        exp_t e;

        vecs[0] = '{0, 9'h0A5, 16'b0101001011_000000, 10, -1};
        vecs[1] = '{0, 9'h03C, 16'b0001111001_000000, 10, 9};
        vecs[2] = '{1, 9'h007, 16'b01110000011_00000, 11, -1};
        vecs[3] = '{1, 9'h0FF, 16'b01111111101_00000, 11, -1};
        vecs[4] = '{2, 9'h007, 16'b011100000011_0000, 12, -1};
        vecs[5] = '{2, 9'h080, 16'b000000001011_0000, 12, -1};
        vecs[6] = '{3, 9'h041, 16'b010000011_0000000, 9, -1};
        vecs[7] = '{3, 9'h02A, 16'b001010101_0000000, 9, -1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_tx", 16'(tx_w[d]), 16'd1);
            chk("rst_busy", 16'(busy_w[d]), 16'd0);
            chk("rst_ready", 16'(ready_w[d]), 16'd1);
            chk("rst_done", 16'(done_w[d]), 16'd0);
        end

        for (int i = 0; i < 8; i++) begin
            c0 = done_cnt[vecs[i].dut];
            begin_frame(vecs[i].dut, vecs[i].data, vecs[i].bits,
                        vecs[i].nbits, 1'b0);
            check_frame(vecs[i].pulse_at);
            @(negedge clk);
            chk("done_one_cycle", 16'(done_w[vecs[i].dut]), 16'd0);
            chk("done_count", 16'(done_cnt[vecs[i].dut] - c0), 16'd1);
            repeat (2) @(negedge clk);
        end

        abort_test(1'b0);
        abort_test(1'b1);

        // Back-to-back frames with txStart held high.
        c0 = done_cnt[0];
        begin_frame(0, 9'h055, 16'b0101010101_000000, 10, 1'b1);
        din[0] = 9'h0AA;
        e.dut = 0;
        e.bits = 16'b0010101011_000000;
        e.nbits = 10;
        sb.push_back(e);
        check_frame(-1);
        @(negedge clk);
        start_r[0] = 1'b0;
        check_frame(-1);
        @(negedge clk);
        chk("b2b_done_low", 16'(done_w[0]), 16'd0);
        chk("b2b_tx_idle", 16'(tx_w[0]), 16'd1);
        chk("b2b_done_count", 16'(done_cnt[0] - c0), 16'd2);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
